// File: rtl/dcache_controller_pkg.sv
// Shared types, field widths and byte helpers for the direct-mapped data cache.
package dcache_controller_pkg;

    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int TAG_W       = 3;
    localparam int INDEX_W     = $clog2(NUM_BLOCKS);
    localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
    localparam int BLOCK_W     = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    // Byte lane select; byte 0 lives in bits [7:0].
    function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFFSET_W-1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = blk[7:0];
            2'd1:    b = blk[15:8];
            2'd2:    b = blk[23:16];
            default: b = blk[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] blk,
                                                    input logic [OFFSET_W-1:0] off,
                                                    input logic [7:0]          b);
        logic [BLOCK_W-1:0] r;
        r = blk;
        case (off)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Cache line storage: valid/dirty/tag/data with a combinational read port,
// a byte-write port (sets dirty) and a block-fill port (clean, valid line).
module dcache_line_array
    import dcache_controller_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [INDEX_W-1:0]  i_rd_index,
    output logic                o_rd_valid,
    output logic                o_rd_dirty,
    output logic [TAG_W-1:0]    o_rd_tag,
    output logic [BLOCK_W-1:0]  o_rd_data,
    input  logic                i_wr_en,
    input  logic [INDEX_W-1:0]  i_wr_index,
    input  logic [OFFSET_W-1:0] i_wr_offset,
    input  logic [7:0]          i_wr_byte,
    input  logic                i_fill_en,
    input  logic [INDEX_W-1:0]  i_fill_index,
    input  logic [TAG_W-1:0]    i_fill_tag,
    input  logic [BLOCK_W-1:0]  i_fill_data
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_dirty = r_dirty[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

    // Line state update; reset only clears the status bits, tag/data are don't-care.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_fill_index] <= 1'b1;
            r_dirty[i_fill_index] <= 1'b0;
            r_tag[i_fill_index]   <= i_fill_tag;
            r_data[i_fill_index]  <= i_fill_data;
        end else if (i_wr_en) begin
            r_dirty[i_wr_index] <= 1'b1;
            r_data[i_wr_index]  <= put_byte(r_data[i_wr_index], i_wr_offset, i_wr_byte);
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are serviced with zero stall; misses sequence WRITEBACK -> FETCH -> UPDATE.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic [7:0]               ADDRESS,
    input  logic [7:0]               WRITEDATA,
    output logic [7:0]               READDATA,
    output logic                     BUSYWAIT,
    output logic                     MEM_READ,
    output logic                     MEM_WRITE,
    output logic [TAG_W+INDEX_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]       MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]       MEM_READDATA,
    input  logic                     MEM_BUSYWAIT
);

    state_t                    r_state;
    logic                      r_first;
    logic [TAG_W-1:0]          r_miss_tag;
    logic [INDEX_W-1:0]        r_miss_index;
    logic [BLOCK_W-1:0]        r_fill;
    logic                      r_mem_read;
    logic                      r_mem_write;
    logic [TAG_W+INDEX_W-1:0]  r_mem_address;
    logic [BLOCK_W-1:0]        r_mem_writedata;
    logic [7:0]                r_readdata;

    logic [TAG_W-1:0]          w_tag;
    logic [INDEX_W-1:0]        w_index;
    logic [OFFSET_W-1:0]       w_offset;
    logic                      w_line_valid;
    logic                      w_line_dirty;
    logic [TAG_W-1:0]          w_line_tag;
    logic [BLOCK_W-1:0]        w_line_data;
    logic                      w_req;
    logic                      w_rd_only;
    logic                      w_hit;
    logic                      w_idle;
    logic                      w_byte_we;
    logic                      w_fill_en;

    assign w_tag     = ADDRESS[7:5];
    assign w_index   = ADDRESS[4:2];
    assign w_offset  = ADDRESS[1:0];
    assign w_req     = READ | WRITE;
    assign w_rd_only = READ & ~WRITE;
    assign w_hit     = w_line_valid && (w_line_tag == w_tag);
    assign w_idle    = (r_state == IDLE);
    assign w_byte_we = w_idle & WRITE & w_hit;
    assign w_fill_en = (r_state == UPDATE);

    assign BUSYWAIT      = !w_idle || (w_req && !w_hit);
    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = r_mem_address;
    assign MEM_WRITEDATA = r_mem_writedata;

    // Read hits bypass the register so they cost no stall cycle.
    always_comb begin
        if (w_idle && w_rd_only && w_hit) begin
            READDATA = get_byte(w_line_data, w_offset);
        end else begin
            READDATA = r_readdata;
        end
    end

    dcache_line_array u_lines (
        .i_clk        (CLK),
        .i_rst        (RESET),
        .i_rd_index   (w_index),
        .o_rd_valid   (w_line_valid),
        .o_rd_dirty   (w_line_dirty),
        .o_rd_tag     (w_line_tag),
        .o_rd_data    (w_line_data),
        .i_wr_en      (w_byte_we),
        .i_wr_index   (w_index),
        .i_wr_offset  (w_offset),
        .i_wr_byte    (WRITEDATA),
        .i_fill_en    (w_fill_en),
        .i_fill_index (r_miss_index),
        .i_fill_tag   (r_miss_tag),
        .i_fill_data  (r_fill)
    );

    // Miss sequencer; r_first marks the ignored entry cycle of each memory phase.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state         <= IDLE;
            r_first         <= 1'b0;
            r_miss_tag      <= '0;
            r_miss_index    <= '0;
            r_fill          <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_readdata      <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !w_hit) begin
                        r_miss_tag   <= w_tag;
                        r_miss_index <= w_index;
                        r_first      <= 1'b1;
                        if (w_line_valid && w_line_dirty) begin
                            r_state         <= WRITEBACK;
                            r_mem_write     <= 1'b1;
                            r_mem_address   <= {w_line_tag, w_index};
                            r_mem_writedata <= w_line_data;
                        end else begin
                            r_state       <= FETCH;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= {w_tag, w_index};
                        end
                    end else if (w_rd_only && w_hit) begin
                        r_readdata <= get_byte(w_line_data, w_offset);
                    end
                end
                WRITEBACK: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else if (!MEM_BUSYWAIT) begin
                        r_state       <= FETCH;
                        r_first       <= 1'b1;
                        r_mem_write   <= 1'b0;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= {r_miss_tag, r_miss_index};
                    end
                end
                FETCH: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else if (!MEM_BUSYWAIT) begin
                        r_state    <= UPDATE;
                        r_mem_read <= 1'b0;
                        r_fill     <= MEM_READDATA;
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus random
// accesses checked against a line-level cache model and a latency-varying memory.
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = 32'h0;
    logic        MEM_BUSYWAIT = 1'b0;

    int checks = 0;
    int errors = 0;

    dcache_controller dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: init_mem/ref_mem owned by the initial block, dut_mem by the responder.
    logic [31:0] init_mem [64];
    logic [31:0] dut_mem  [64];
    logic [31:0] ref_mem  [64];
    logic        load_mem = 1'b0;
    int          force_lat = -1;
    int          lat;
    int          cnt = 0;
    int          both_high = 0;
    logic [1:0]  act_kind = 2'b00;
    int          lat_q[$];
    logic [5:0]  wb_addr_q[$];
    logic [31:0] wb_data_q[$];
    logic [5:0]  rd_addr_q[$];

    // Cache model
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_data  [8];
    logic [7:0]  m_last_rd;

    always @(posedge CLK) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) dut_mem[i] <= init_mem[i];
        end
        if (MEM_READ && MEM_WRITE) both_high <= both_high + 1;
        if (!(MEM_READ || MEM_WRITE)) begin
            act_kind     <= 2'b00;
            MEM_BUSYWAIT <= 1'b0;
        end else if (act_kind != {MEM_READ, MEM_WRITE}) begin
            lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            act_kind     <= {MEM_READ, MEM_WRITE};
            cnt          <= lat;
            MEM_BUSYWAIT <= (lat != 0);
            lat_q.push_back(lat);
            if (MEM_WRITE) begin
                dut_mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                wb_addr_q.push_back(MEM_ADDRESS);
                wb_data_q.push_back(MEM_WRITEDATA);
            end else begin
                MEM_READDATA <= dut_mem[MEM_ADDRESS];
                rd_addr_q.push_back(MEM_ADDRESS);
            end
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) MEM_BUSYWAIT <= 1'b0;
        end
    end

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] o);
        return w[8*int'(o) +: 8];
    endfunction

    function automatic logic [31:0] with_byte(input logic [31:0] w, input logic [1:0] o,
                                              input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[8*int'(o) +: 8] = b;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_last_rd = 8'h00;
    endtask

    task automatic model_fill(input logic [2:0] tg, input logic [2:0] idx);
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b0;
        m_tag[idx]   = tg;
        m_data[idx]  = ref_mem[{tg, idx}];
    endtask

    // One CPU access held until BUSYWAIT drops; returns #1 after the completing edge.
    task automatic access(input logic wr, input logic both, input logic [7:0] a,
                          input logic [7:0] d);
        int i0w, i0r, i0l, cycles, exp_cycles;
        logic [2:0] idx, tg;
        logic [1:0] off;
        logic hit, vict;
        idx = a[4:2];
        tg  = a[7:5];
        off = a[1:0];
        i0w = wb_addr_q.size();
        i0r = rd_addr_q.size();
        i0l = lat_q.size();
        @(negedge CLK);
        WRITE = wr;
        READ = wr ? both : 1'b1;
        ADDRESS = a;
        WRITEDATA = d;
        #1;
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        vict = m_valid[idx] && m_dirty[idx];
        chk("busy_first", 32'(BUSYWAIT), 32'(!hit));
        if (!hit) begin
            cycles = 1;
            for (int k = 0; k < 200 && BUSYWAIT !== 1'b0; k++) begin
                @(negedge CLK);
                #1;
                if (BUSYWAIT === 1'b1) cycles++;
            end
            chk("busy_timeout", 32'(BUSYWAIT), 32'(0));
            chk("wb_count", 32'(wb_addr_q.size() - i0w), vict ? 32'd1 : 32'd0);
            chk("fetch_count", 32'(rd_addr_q.size() - i0r), 32'd1);
            if (vict && wb_addr_q.size() > i0w) begin
                chk("wb_addr", 32'(wb_addr_q[i0w]), 32'({m_tag[idx], idx}));
                chk("wb_data", wb_data_q[i0w], m_data[idx]);
            end
            if (vict) ref_mem[{m_tag[idx], idx}] = m_data[idx];
            if (rd_addr_q.size() > i0r) chk("fetch_addr", 32'(rd_addr_q[i0r]), 32'({tg, idx}));
            exp_cycles = 2;
            for (int j = i0l; j < lat_q.size(); j++) exp_cycles += 2 + lat_q[j];
            chk("stall_cycles", 32'(cycles), 32'(exp_cycles));
            model_fill(tg, idx);
        end
        chk("strobes_idle", 32'({MEM_READ, MEM_WRITE}), 32'd0);
        if (!wr) begin
            chk("readdata", 32'(READDATA), 32'(byte_of(m_data[idx], off)));
            m_last_rd = byte_of(m_data[idx], off);
        end else begin
            m_data[idx]  = with_byte(m_data[idx], off, d);
            m_dirty[idx] = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_check();
        @(negedge CLK);
        READ = 1'b0;
        WRITE = 1'b0;
        #1;
        chk("idle_busy", 32'(BUSYWAIT), 32'd0);
        chk("idle_hold_readdata", 32'(READDATA), 32'(m_last_rd));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, 32'(BUSYWAIT), 32'd0);
        chk({tag, "_memstrobes"}, 32'({MEM_READ, MEM_WRITE}), 32'd0);
        chk({tag, "_memaddr"}, 32'(MEM_ADDRESS), 32'd0);
        chk({tag, "_memwdata"}, MEM_WRITEDATA, 32'd0);
        chk({tag, "_readdata"}, 32'(READDATA), 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] a;
        for (int i = 0; i < 64; i++) begin
            init_mem[i] = $urandom;
            ref_mem[i]  = init_mem[i];
        end
        init_mem[1] = 32'hDDCCBBAA;
        ref_mem[1]  = 32'hDDCCBBAA;
        model_reset();

        // Power-on reset
        load_mem = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        load_mem = 1'b0;
        RESET = 1'b0;
        #1;
        reset_checks("reset");

        // Read miss, then read hit in the same block
        access(1'b0, 1'b0, 8'h05, 8'h00);
        chk("tp_read05", 32'(READDATA), 32'h000000BB);
        n = rd_addr_q.size();
        access(1'b0, 1'b0, 8'h07, 8'h00);
        chk("tp_read07", 32'(READDATA), 32'h000000DD);
        chk("tp_hit_no_fetch", 32'(rd_addr_q.size()), 32'(n));

        // Write hit then conflicting read forces write-back
        access(1'b1, 1'b0, 8'h04, 8'h11);
        access(1'b0, 1'b0, 8'h24, 8'h00);
        chk("tp_wb_addr", 32'(wb_addr_q[wb_addr_q.size()-1]), 32'h01);
        chk("tp_wb_data", wb_data_q[wb_data_q.size()-1], 32'hDDCCBB11);
        chk("tp_fetch_addr", 32'(rd_addr_q[rd_addr_q.size()-1]), 32'h09);

        // Write miss on an invalid line, then read back; READ+WRITE counts as write
        access(1'b1, 1'b1, 8'hE3, 8'h7F);
        access(1'b0, 1'b0, 8'hE3, 8'h00);
        chk("tp_write_miss", 32'(READDATA), 32'h7F);
        access(1'b0, 1'b0, 8'h03, 8'h00);
        idle_check();

        // Reset in the middle of a long fetch
        force_lat = 8;
        @(negedge CLK);
        READ = 1'b1;
        WRITE = 1'b0;
        ADDRESS = 8'h54;
        for (int k = 0; k < 20 && MEM_READ !== 1'b1; k++) @(negedge CLK);
        @(negedge CLK);
        chk("rst_fetch_active", 32'(MEM_READ), 32'd1);
        RESET = 1'b1;
        READ = 1'b0;
        @(posedge CLK);
        #1;
        reset_checks("midreset");
        @(negedge CLK);
        RESET = 1'b0;
        force_lat = -1;
        model_reset();
        access(1'b0, 1'b0, 8'h54, 8'h00);

        // Request dropped during a fetch: fill still completes
        force_lat = 3;
        @(negedge CLK);
        READ = 1'b1;
        WRITE = 1'b0;
        ADDRESS = 8'h9A;
        repeat (2) @(negedge CLK);
        READ = 1'b0;
        for (int k = 0; k < 50 && BUSYWAIT !== 1'b0; k++) @(negedge CLK);
        #1;
        chk("drop_busy", 32'(BUSYWAIT), 32'd0);
        chk("drop_strobes", 32'({MEM_READ, MEM_WRITE}), 32'd0);
        model_fill(3'd4, 3'd6);
        force_lat = -1;
        access(1'b0, 1'b0, 8'h9A, 8'h00);

        // Random traffic
        for (int t = 0; t < 200; t++) begin
            a = {3'($urandom_range(0, 2)), 5'($urandom)};
            access(1'($urandom), 1'($urandom), a, 8'($urandom));
            if ($urandom_range(0, 7) == 0) idle_check();
        end

        chk("strobes_exclusive", 32'(both_high), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
